// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, data and handshake signals between four requesters,
// the round-robin arbiter and its single downstream consumer.
// master: requester/consumer side; slave: the arbiter itself.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_c;
  logic [WIDTH-1:0] data_d;
  logic [3:0]       lock;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [3:0]       ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output req, data_a, data_b, data_c, data_d, lock, out_ready,
    input  gnt, sel, ack, out_valid, out_data
  );

  modport slave (
    input  req, data_a, data_b, data_c, data_d, lock, out_ready,
    output gnt, sel, ack, out_valid, out_data
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-to-1 datapath mux.
// Grants one requester at a time and passes its word downstream over a
// valid/ready handshake with no bubble between back-to-back transfers.
// Optional burst locking is compiled in with the ARB_LOCK_EN macro.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [1:0] last_q, last_d;

  logic       accept;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;

  // First requester at or after ptr+1 (wrapping) whose bit in r is set.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign accept    = valid_q & bus.out_ready;
  assign others    = bus.req & ~gnt_q;
  assign pick_idle = rr_pick(bus.req, last_q);
  assign pick_next = rr_pick(others, sel_q);

`ifdef ARB_LOCK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       keep_burst;

  assign keep_burst = bus.lock[sel_q] && (({1'b0, cnt_q} + 9'd1) < 9'(MAX_BURST));
`else
  logic unused_lock;

  assign unused_lock = ^{bus.lock, 8'(MAX_BURST)};
`endif

  // Next-state logic: idle pick, hold while stalled, re-arbitrate on accept,
  // release on an owner dropping its request without an accept.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = 4'b0001 << pick_idle;
          sel_d   = pick_idle;
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
`ifdef ARB_LOCK_EN
          if (keep_burst) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d  = 8'd0;
`endif
            last_d = sel_q;
            if (|others) begin
              gnt_d   = 4'b0001 << pick_next;
              sel_d   = pick_next;
              valid_d = 1'b1;
            end else begin
              gnt_d   = 4'b0000;
              valid_d = 1'b0;
              state_d = IDLE;
            end
`ifdef ARB_LOCK_EN
          end
`endif
        end else if (!bus.req[sel_q]) begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef ARB_LOCK_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; last-served pointer starts at 3 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
`ifdef ARB_LOCK_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = gnt_q & {4{accept}};

  // Output word mux; forced to zero whenever no word is being presented.
  always_comb begin
    bus.out_data = '0;
    if (valid_q) begin
      case (sel_q)
        2'd0:    bus.out_data = bus.data_a;
        2'd1:    bus.out_data = bus.data_b;
        2'd2:    bus.out_data = bus.data_c;
        default: bus.out_data = bus.data_d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter with a scoreboard for accepted beats.
// Behaviour with ARB_LOCK_EN defined follows the same macro.
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] dw [4];
  beat_t       exp_q [$];
  int          checks;
  int          errors;

  mux4_rr_arbiter_if #(.WIDTH(32)) bus ();

  assign bus.data_a = dw[0];
  assign bus.data_b = dw[1];
  assign bus.data_c = dw[2];
  assign bus.data_d = dw[3];

  mux4_rr_arbiter #(.WIDTH(32), .MAX_BURST(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    bus.req       = r;
    bus.lock      = l;
    bus.out_ready = rdy;
  endtask

  task automatic expectBeat(input logic [1:0] idx);
    beat_t b;
    b.idx  = idx;
    b.data = dw[idx];
    exp_q.push_back(b);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic [3:0] ea, input logic [31:0] ed);
    checks++;
    if ({bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data} !== {eg, es, ev, ea, ed}) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b sel=%0d valid=%b ack=%b data=%h, required gnt=%b sel=%0d valid=%b ack=%b data=%h",
               name, bus.gnt, bus.sel, bus.out_valid, bus.ack, bus.out_data, eg, es, ev, ea, ed);
    end
  endtask

  // Scoreboard monitor: every accepted beat is compared with the next expectation.
  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got gnt=%b sel=%0d data=%h, required no beat",
                   bus.gnt, bus.sel, bus.out_data);
        end else begin
          b = exp_q.pop_front();
          if (bus.gnt !== (4'b0001 << b.idx) || bus.ack !== (4'b0001 << b.idx) ||
              bus.sel !== b.idx || bus.out_data !== b.data) begin
            errors++;
            $display("[TB] FAIL beat: got gnt=%b ack=%b sel=%0d data=%h, required gnt=%b ack=%b sel=%0d data=%h",
                     bus.gnt, bus.ack, bus.sel, bus.out_data,
                     4'b0001 << b.idx, 4'b0001 << b.idx, b.idx, b.data);
          end
        end
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    dw[0] = 32'hAAAA0000;
    dw[1] = 32'hBBBB1111;
    dw[2] = 32'hCCCC2222;
    dw[3] = 32'hDDDD3333;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    fork
      monitor();
    join_none

    #3;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 4'b0000, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // All four requesting: grants rotate 0,1,2,3,0 with no gaps
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    expectBeat(2'd0); expectBeat(2'd1); expectBeat(2'd2); expectBeat(2'd3); expectBeat(2'd0);
    for (int i = 0; i < 5; i++) step();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("rotate_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 32'h0);

    // Single requester stalled by out_ready for 5 cycles
    dw[2] = 32'hDEADBEEF;
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_hold", 4'b0100, 2'd2, 1'b1, 4'b0000, 32'hDEADBEEF);
      step();
    end
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    expectBeat(2'd2);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("stall_done_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 32'h0);

    // Asynchronous reset while a word is presented
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    step();
    checkOutput("pre_reset_grant", 4'b0001, 2'd0, 1'b1, 4'b0000, 32'hAAAA0000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    expectBeat(2'd3);
    step();
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("after_reset_idle", 4'b0000, 2'd3, 1'b0, 4'b0000, 32'h0);

    // Owner 1 drops its request without an accept: release, pointer unchanged
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    step();
    checkOutput("violation_grant", 4'b0010, 2'd1, 1'b1, 4'b0000, 32'hBBBB1111);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step();
    checkOutput("violation_release", 4'b0000, 2'd1, 1'b0, 4'b0000, 32'h0);
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    expectBeat(2'd1); expectBeat(2'd2);
    step();
    checkOutput("violation_regrant", 4'b0010, 2'd1, 1'b1, 4'b0010, 32'hBBBB1111);
    step();
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("violation_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 32'h0);

    // Request rising during the owner's accept joins that re-arbitration
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    step();
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    expectBeat(2'd0); expectBeat(2'd2);
    step();
    checkOutput("no_bubble", 4'b0100, 2'd2, 1'b1, 4'b0100, 32'hDEADBEEF);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Burst lock on requester 0
    applyStimulus(4'b0011, 4'b0001, 1'b1);
`ifdef ARB_LOCK_EN
    expectBeat(2'd0); expectBeat(2'd0); expectBeat(2'd0); expectBeat(2'd1);
`else
    expectBeat(2'd0); expectBeat(2'd1); expectBeat(2'd0); expectBeat(2'd1);
`endif
    for (int i = 0; i < 4; i++) step();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("lock_idle", 4'b0000, 2'd1, 1'b0, 4'b0000, 32'h0);

    // Every expected beat must have been consumed
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d beats outstanding, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
